dlfloat_round_pipe: RTL and testbench

- Parametrised, two-stage pipelined rounding unit for the DLfloat datapath.
- Takes an unrounded result {sign, exp, mant, guard/round/sticky bits} from the adder or multiplier normaliser.
- Applies one of five per-beat rounding modes, handles mantissa carry and exponent overflow, and emits a packed DLfloat word plus exception flags.
- Uses a valid/ready handshake on both sides, with full-throughput backpressure.

---
 rtl/dlfloat_round_pipe.sv | 121 ++++++++++++
 tb/tb_dlfloat_round_pipe.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/dlfloat_round_pipe.sv
// rtl/dlfloat_round_pipe.sv - two-stage DLfloat rounding pipeline with valid/ready handshake
// Optional sticky exception flags when DLFLOAT_ROUND_STICKY_FLAGS_EN is defined.
module dlfloat_round_pipe #(
  parameter int EW = 6,
  parameter int MW = 9,
  parameter int GW = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [EW+MW+GW:0]     in_data,
  input  logic [2:0]            in_rm,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [EW+MW:0]        out_data,
  output logic                  out_inexact,
  output logic                  out_overflow,
`ifdef DLFLOAT_ROUND_STICKY_FLAGS_EN
  input  logic                  flag_clr,
  output logic [2:0]            sticky_flags,
`endif
  output logic                  out_bad_rm
);

  localparam int DW = 1 + EW + MW + GW;

  logic          en1, en2;
  logic          s1_valid;
  logic          s1_sign;
  logic [EW-1:0] s1_exp;
  logic [MW-1:0] s1_mant;
  logic          s1_g, s1_r, s1_s;
  logic [2:0]    s1_rm;

  logic          bad_rm, special, any_grs, inc_raw, inc, inexact, overflow;
  logic [EW+MW:0] sum;
  logic [EW+MW:0] result;

  assign en2      = !out_valid || out_ready;
  assign en1      = !s1_valid || en2;
  assign in_ready = en1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_sign  <= 1'b0;
      s1_exp   <= '0;
      s1_mant  <= '0;
      s1_g     <= 1'b0;
      s1_r     <= 1'b0;
      s1_s     <= 1'b0;
      s1_rm    <= 3'd0;
    end else if (en1) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_sign <= in_data[DW-1];
        s1_exp  <= in_data[DW-2 -: EW];
        s1_mant <= in_data[GW +: MW];
        s1_g    <= in_data[GW-1];
        s1_r    <= in_data[GW-2];
        s1_s    <= |in_data[GW-3:0];
        s1_rm   <= in_rm;
      end
    end
  end

  always_comb begin
    bad_rm  = (s1_rm > 3'd4);
    special = (&s1_exp) && (&s1_mant);
    any_grs = s1_g | s1_r | s1_s;
    inc_raw = 1'b0;
    case (s1_rm)
      3'd1:    inc_raw = 1'b0;
      3'd2:    inc_raw = any_grs & ~s1_sign;
      3'd3:    inc_raw = any_grs & s1_sign;
      3'd4:    inc_raw = s1_g;
      default: inc_raw = s1_g & (s1_r | s1_s | s1_mant[0]);
    endcase
    inc     = inc_raw & ~special;
    inexact = any_grs & ~special;
    // Carry out of the mantissa naturally bumps the exponent in this joint add.
    sum      = {1'b0, s1_exp, s1_mant} + {{(EW+MW){1'b0}}, inc};
    overflow = ~special & (sum[EW+MW] | (&sum[EW+MW-1:0]));
    if (special)
      result = {s1_sign, s1_exp, s1_mant};
    else if (overflow)
      result = {s1_sign, {EW{1'b1}}, {(MW-1){1'b1}}, 1'b0};
    else
      result = {s1_sign, sum[EW+MW-1:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_inexact  <= 1'b0;
      out_overflow <= 1'b0;
      out_bad_rm   <= 1'b0;
    end else if (en2) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= result;
        out_inexact  <= inexact | overflow;
        out_overflow <= overflow;
        out_bad_rm   <= bad_rm;
      end
    end
  end

`ifdef DLFLOAT_ROUND_STICKY_FLAGS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sticky_flags <= 3'b000;
    else
      sticky_flags <= (flag_clr ? 3'b000 : sticky_flags) |
                      ((out_valid && out_ready) ? {out_bad_rm, out_overflow, out_inexact} : 3'b000);
  end
`endif

endmodule

// File: tb/tb_dlfloat_round_pipe.sv
// tb/tb_dlfloat_round_pipe.sv - directed self-checking bench for dlfloat_round_pipe
module tb_dlfloat_round_pipe;

  typedef struct packed {
    logic [19:0] data;
    logic [2:0]  rm;
    logic [15:0] res;
    logic        inex;
    logic        ovf;
    logic        bad;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [19:0] in_data = '0;
  logic [2:0]  in_rm = 3'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [15:0] out_data;
  logic        out_inexact, out_overflow, out_bad_rm;
`ifdef DLFLOAT_ROUND_STICKY_FLAGS_EN
  logic        flag_clr = 1'b0;
  logic [2:0]  sticky_flags;
`endif

  int n_vec = 0;
  int n_bad = 0;
  vec_t vecs[14];

  always #5 clk = ~clk;

  dlfloat_round_pipe dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_rm(in_rm),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_inexact(out_inexact), .out_overflow(out_overflow),
`ifdef DLFLOAT_ROUND_STICKY_FLAGS_EN
    .flag_clr(flag_clr), .sticky_flags(sticky_flags),
`endif
    .out_bad_rm(out_bad_rm)
  );

  task automatic init_vecs();
    vecs[0]  = '{20'h3EFF8, 3'd0, 16'h3F00, 1'b1, 1'b0, 1'b0};
    vecs[1]  = '{20'h3EFE8, 3'd0, 16'h3EFE, 1'b1, 1'b0, 1'b0};
    vecs[2]  = '{20'h3FFFC, 3'd0, 16'h4000, 1'b1, 1'b0, 1'b0};
    vecs[3]  = '{20'h7FFEC, 3'd0, 16'h7FFE, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{20'h7FFFF, 3'd2, 16'h7FFF, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{20'hBEFF4, 3'd2, 16'hBEFF, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{20'hBEFF4, 3'd3, 16'hBF00, 1'b1, 1'b0, 1'b0};
    vecs[7]  = '{20'hBEFF4, 3'd7, 16'hBEFF, 1'b1, 1'b0, 1'b1};
    vecs[8]  = '{20'h3EFF8, 3'd1, 16'h3EFF, 1'b1, 1'b0, 1'b0};
    vecs[9]  = '{20'h3EFE8, 3'd4, 16'h3EFF, 1'b1, 1'b0, 1'b0};
    vecs[10] = '{20'h12340, 3'd2, 16'h1234, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{20'h3EFE9, 3'd0, 16'h3EFF, 1'b1, 1'b0, 1'b0};
    vecs[12] = '{20'hFFFEC, 3'd0, 16'hFFFE, 1'b1, 1'b1, 1'b0};
    vecs[13] = '{20'h3EFE4, 3'd5, 16'h3EFE, 1'b1, 1'b0, 1'b1};
  endtask

  task automatic test_reset();
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
      n_bad++;
      $display("FAIL reset_out: valid=%b data=%h, required valid=0 data=0000", out_valid, out_data);
    end
    n_vec++;
    if ({out_inexact, out_overflow, out_bad_rm} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_flags: got %b required 000", {out_inexact, out_overflow, out_bad_rm});
    end
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_bad++;
      $display("FAIL reset_in_ready: got %b required 1", in_ready);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rounding();
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vecs[i].data;
      in_rm    = vecs[i].rm;
      @(negedge clk);
      in_valid = 1'b0;
      in_rm    = 3'd1;
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL early_valid[%0d]: got %b required 0", i, out_valid);
      end
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL latency[%0d]: out_valid got %b required 1", i, out_valid);
      end
      n_vec++;
      if (out_data !== vecs[i].res) begin
        n_bad++;
        $display("FAIL data[%0d]: got %h required %h", i, out_data, vecs[i].res);
      end
      n_vec++;
      if ({out_inexact, out_overflow, out_bad_rm} !== {vecs[i].inex, vecs[i].ovf, vecs[i].bad}) begin
        n_bad++;
        $display("FAIL flags[%0d]: got ixb=%b required %b", i,
                 {out_inexact, out_overflow, out_bad_rm}, {vecs[i].inex, vecs[i].ovf, vecs[i].bad});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    int tx = 0;
    int rx = 0;
    out_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      in_valid = (tx < 4);
      if (tx < 4) begin
        in_data = vecs[tx].data;
        in_rm   = vecs[tx].rm;
      end
      #1;
      if (in_valid && in_ready) tx++;
    end
    n_vec++;
    if (tx != 2) begin
      n_bad++;
      $display("FAIL stall_accepts: got %0d required 2", tx);
    end
    n_vec++;
    if (in_ready !== 1'b0) begin
      n_bad++;
      $display("FAIL stall_in_ready: got %b required 0", in_ready);
    end
    n_vec++;
    if (out_valid !== 1'b1 || out_data !== vecs[0].res) begin
      n_bad++;
      $display("FAIL stall_hold: valid=%b data=%h required 1/%h", out_valid, out_data, vecs[0].res);
    end
    for (int c = 0; c < 30 && rx < 4; c++) begin
      @(negedge clk);
      out_ready = 1'b1;
      in_valid  = (tx < 4);
      if (tx < 4) begin
        in_data = vecs[tx].data;
        in_rm   = vecs[tx].rm;
      end
      #1;
      if (out_valid) begin
        n_vec++;
        if (out_data !== vecs[rx].res) begin
          n_bad++;
          $display("FAIL drain[%0d]: got %h required %h", rx, out_data, vecs[rx].res);
        end
        rx++;
      end
      if (in_valid && in_ready) tx++;
    end
    in_valid = 1'b0;
    n_vec++;
    if (rx != 4 || tx != 4) begin
      n_bad++;
      $display("FAIL drain_count: rx=%0d tx=%0d required 4/4", rx, tx);
    end
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL drain_dup: out_valid got %b required 0", out_valid);
    end
  endtask

  task automatic test_reset_midstream();
    int stale = 0;
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = vecs[c].data;
      in_rm    = vecs[c].rm;
    end
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_data !== 16'h0000) begin
      n_bad++;
      $display("FAIL async_reset: valid=%b data=%h required 0/0000", out_valid, out_data);
    end
    in_valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    n_vec++;
    if (stale != 0) begin
      n_bad++;
      $display("FAIL stale_after_reset: %0d cycles with out_valid, required 0", stale);
    end
  endtask

`ifdef DLFLOAT_ROUND_STICKY_FLAGS_EN
  task automatic test_sticky();
    n_vec++;
    if (sticky_flags !== 3'b000) begin
      n_bad++;
      $display("FAIL sticky_init: got %b required 000", sticky_flags);
    end
    @(negedge clk);
    in_valid = 1'b1;
    in_data  = 20'h7FFEC;
    in_rm    = 3'd6;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_vec++;
    if (sticky_flags !== 3'b111) begin
      n_bad++;
      $display("FAIL sticky_set: got %b required 111", sticky_flags);
    end
    flag_clr = 1'b1;
    @(negedge clk);
    flag_clr = 1'b0;
    n_vec++;
    if (sticky_flags !== 3'b000) begin
      n_bad++;
      $display("FAIL sticky_clr: got %b required 000", sticky_flags);
    end
  endtask
`endif

  initial begin
    init_vecs();
    test_reset();
    test_rounding();
    test_backpressure();
    test_reset_midstream();
`ifdef DLFLOAT_ROUND_STICKY_FLAGS_EN
    test_sticky();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
